gs_fmt_monitor: RTL and testbench
=================================

# gs_fmt_monitor

Poll scheduler and format qualifier for the GS2961 SPI status path. Drives the `stat_poll` request of the GS2961 SPI register reader at a fixed period and counts one full register sweep per round. After each complete round it snapshots the reader's `vid_std` and `raster1..4` outputs. It publishes a latched, debounced video format once the snapshot has stayed identical for a configurable number of consecutive rounds, and it signals lock loss on any change.

## Interface
- `POLL_PERIOD`, 4096: cycles between poll requests; must be ≥ 64 × reader SPI clock divider so that every request lands while the reader is idle.
- `REGS_PER_ROUND`, 6: number of poll requests that make up one full register sweep.
- `STABLE_ROUNDS`, 3: number of consecutive equal snapshot compares required to lock; must be ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `enable`  in  1  level; polling and qualification run only while high.
- `stat_poll`  out  1  one-cycle poll request to the SPI reader.
- `vid_std`  in  32  live value from the reader.
- `raster1..raster4`  in  16 each  live values from the reader.
- `fmt_vid_std`  out  32  latched, qualified vid_std.
- `fmt_raster1..fmt_raster4`  out  16 each  latched, qualified rasters.
- `fmt_locked`  out  1  high while the qualified format is valid.
- `fmt_update`  out  1  one-cycle pulse when `fmt_*` is (re)loaded.
- `fmt_lost`  out  1  one-cycle pulse when lock drops because the snapshot changed.

## Operation
- Timer `tmr` counts 0..POLL_PERIOD-1 while `enable` is high. `tick` is asserted when `tmr == POLL_PERIOD-1`.
- Slot counter `slot` counts 0..REGS_PER_ROUND.
  - On `tick` with `slot < REGS_PER_ROUND`: issue a poll and increment `slot`.
  - On `tick` with `slot == REGS_PER_ROUND`: perform the round check, issue a poll, and set `slot <= 1`.
- The round check therefore samples the inputs one full period after the last poll of the round, when the final read is complete.
- Snapshot `cur = {vid_std, raster1, raster2, raster3, raster4}`, 96 bits. The compare is an exact bitwise equality against `prev`.
- Internal state: `prev` (96 bits), `prev_valid`, `match_cnt` (0..STABLE_ROUNDS-1), and FSM {ST_UNLOCKED, ST_LOCKED}.
- Round check rules:
  - `!prev_valid`: load `prev <= cur`, set `prev_valid <= 1`, and make no decision.
  - `cur != prev`: load `prev <= cur`, set `match_cnt <= 0`. If in ST_LOCKED, move to ST_UNLOCKED, clear `fmt_locked`, and pulse `fmt_lost`.
  - `cur == prev` in ST_UNLOCKED with `match_cnt == STABLE_ROUNDS-1`: move to ST_LOCKED, load `fmt_* <= cur`, set `fmt_locked`, and pulse `fmt_update`.
  - `cur == prev` in ST_UNLOCKED otherwise: increment `match_cnt`.
  - `cur == prev` in ST_LOCKED: no action.
- `enable` low: clear `tmr`, `slot`, `prev_valid`, and `match_cnt`; force ST_UNLOCKED; clear `fmt_locked`. No pulses are produced. `fmt_*` data holds its last value.
- Reset values: `stat_poll`, `fmt_locked`, `fmt_update`, and `fmt_lost` are 0. `fmt_*` data is 0. Internal state is as for `enable` low.
- `rst` asserted mid-round or mid-lock: takes effect on the next edge and restarts from the top. A partial round is never checked.

## Timing
- All outputs are registered. `stat_poll`, check results, and pulses appear in the cycle after `tick`.
- After `enable` rises, the first `stat_poll` occurs POLL_PERIOD cycles later. `stat_poll` then repeats every POLL_PERIOD cycles.
- The first round check occurs on tick REGS_PER_ROUND+1. Later checks occur every REGS_PER_ROUND ticks.
- Earliest lock is on check number STABLE_ROUNDS+1 after enable.
- `fmt_update` and `fmt_lost` never assert in the same cycle, and each lasts exactly one cycle.
- An input change between checks is invisible; only values present at check instants matter.

## Structure
- Package `gs_fmt_pkg` holds:
  - the FSM state enum;
  - `SNAP_W = 96`;
  - snapshot pack/unpack field offsets.
- Sub-module `gs_poll_timer` owns `tmr`, `slot`, `tick`, `stat_poll`, and the round-check strobe, with parameters POLL_PERIOD and REGS_PER_ROUND.
- The top level holds the snapshot compare and the FSM.

## Test plan
Bench parameters: POLL_PERIOD=8, REGS_PER_ROUND=6, STABLE_ROUNDS=2.
- Poll cadence: `rst` pulse, then `enable=1` at cycle 0 → `stat_poll` high for exactly one cycle at cycles 8, 16, 24, …; all outputs 0 during reset.
- Lock: hold `vid_std=32'h0000_1234`, `raster1..4=16'd1125, 16'd2200, 16'd1080, 16'd1920` → checks on ticks 7, 13, 19; `fmt_locked` and a single `fmt_update` appear after tick 19; `fmt_*` equal the inputs.
- Loss and relock: while locked, change `raster1` to 16'd625 → next check pulses `fmt_lost` and drops `fmt_locked`; two further equal checks relock with `fmt_raster1=625`.
- Flicker: `vid_std` alternates 32'h1 / 32'h2 between consecutive checks → `fmt_locked` never rises and no `fmt_update` occurs.
- Enable drop: deassert `enable` mid-round while locked → `fmt_locked` is 0 next cycle and `stat_poll` stops; after re-enable, the tick-7 check only loads `prev`.
- Mid-operation reset: assert `rst` for one cycle while locked → all outputs return to reset values; the cadence restarts so the first `stat_poll` occurs 8 cycles after reset release.

Source files
------------

// File: rtl/gs_fmt_pkg.sv
// Shared types and constants for the GS2961 format monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, snapshot width, snapshot field offsets, pack helper.
package gs_fmt_pkg;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } fmt_state_e;

   localparam int SNAP_W = 96;

   // Snapshot layout, MSB first: {vid_std, raster1, raster2, raster3, raster4}
   localparam int VID_LSB = 64;
   localparam int R1_LSB  = 48;
   localparam int R2_LSB  = 32;
   localparam int R3_LSB  = 16;
   localparam int R4_LSB  = 0;

   function automatic logic [SNAP_W-1:0] pack_snap(
      input logic [31:0] vid,
      input logic [15:0] r1,
      input logic [15:0] r2,
      input logic [15:0] r3,
      input logic [15:0] r4
   );
      return {vid, r1, r2, r3, r4};
   endfunction

endpackage

// File: rtl/gs_poll_timer.sv
// Poll timer: issues one stat_poll per POLL_PERIOD cycles and flags the round-check slot.
// Latency: stat_poll_o is registered, one cycle after the internal tick; round_chk_o is combinational on tick.
// Backpressure: none; the reader is assumed idle at every poll (period sized for a full SPI read).
// Ports: clk_i/rst_i (sync, active-high), enable_i level gate, stat_poll_o pulse, round_chk_o strobe.
module gs_poll_timer #(
   parameter int POLL_PERIOD    = 4096,
   parameter int REGS_PER_ROUND = 6
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable_i,
   output logic stat_poll_o,
   output logic round_chk_o
);

   localparam int TMR_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int SLOT_W = $clog2(REGS_PER_ROUND + 1);

   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic              stat_poll_q;
   logic              tick;

   // Gated by enable so the cycle in which enable drops never fires.
   assign tick        = enable_i && (tmr_q == TMR_W'(POLL_PERIOD - 1));
   // The check runs on the tick after the last poll of a round, so the final read has completed.
   assign round_chk_o = tick && (slot_q == SLOT_W'(REGS_PER_ROUND));
   assign stat_poll_o = stat_poll_q;

   always_comb begin
      tmr_d  = tick ? '0 : tmr_q + 1'b1;
      slot_d = slot_q;
      if (tick) begin
         // The check tick also polls, so it is slot 1 of the next round.
         slot_d = (slot_q == SLOT_W'(REGS_PER_ROUND)) ? SLOT_W'(1) : slot_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !enable_i) begin
         tmr_q       <= '0;
         slot_q      <= '0;
         stat_poll_q <= 1'b0;
      end else begin
         tmr_q       <= tmr_d;
         slot_q      <= slot_d;
         stat_poll_q <= tick;
      end
   end

endmodule

// File: rtl/gs_fmt_monitor.sv
// Format qualifier: snapshots reader status once per round and locks after STABLE_ROUNDS equal compares.
// Latency: all outputs registered; results appear the cycle after the check tick.
// Backpressure: none; inputs are sampled only at check instants, changes between checks are ignored.
// Ports: clk_i/rst_i/enable_i control, stat_poll_o to reader, vid_std_i/raster*_i live status,
//        fmt_* qualified format, fmt_locked_o level, fmt_update_o/fmt_lost_o one-cycle pulses.
module gs_fmt_monitor
   import gs_fmt_pkg::*;
#(
   parameter int POLL_PERIOD    = 4096,
   parameter int REGS_PER_ROUND = 6,
   parameter int STABLE_ROUNDS  = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   output logic        stat_poll_o,
   input  logic [31:0] vid_std_i,
   input  logic [15:0] raster1_i,
   input  logic [15:0] raster2_i,
   input  logic [15:0] raster3_i,
   input  logic [15:0] raster4_i,
   output logic [31:0] fmt_vid_std_o,
   output logic [15:0] fmt_raster1_o,
   output logic [15:0] fmt_raster2_o,
   output logic [15:0] fmt_raster3_o,
   output logic [15:0] fmt_raster4_o,
   output logic        fmt_locked_o,
   output logic        fmt_update_o,
   output logic        fmt_lost_o
);

   localparam int CNT_W = (STABLE_ROUNDS > 1) ? $clog2(STABLE_ROUNDS) : 1;

   logic              round_chk;
   logic [SNAP_W-1:0] cur;
   fmt_state_e        state_q;
   logic [SNAP_W-1:0] prev_q;
   logic              prev_valid_q;
   logic [CNT_W-1:0]  match_cnt_q;
   logic [SNAP_W-1:0] fmt_q;
   logic              locked_q;
   logic              update_q;
   logic              lost_q;

   gs_poll_timer #(
      .POLL_PERIOD    (POLL_PERIOD),
      .REGS_PER_ROUND (REGS_PER_ROUND)
   ) u_timer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .stat_poll_o (stat_poll_o),
      .round_chk_o (round_chk)
   );

   assign cur = pack_snap(vid_std_i, raster1_i, raster2_i, raster3_i, raster4_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_UNLOCKED;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         match_cnt_q  <= '0;
         fmt_q        <= '0;
         locked_q     <= 1'b0;
         update_q     <= 1'b0;
         lost_q       <= 1'b0;
      end else begin
         update_q <= 1'b0;
         lost_q   <= 1'b0;
         if (!enable_i) begin
            // Qualified data is kept for inspection; only its validity is withdrawn.
            state_q      <= ST_UNLOCKED;
            prev_valid_q <= 1'b0;
            match_cnt_q  <= '0;
            locked_q     <= 1'b0;
         end else if (round_chk) begin
            if (!prev_valid_q) begin
               // First full round only seeds the reference.
               prev_q       <= cur;
               prev_valid_q <= 1'b1;
            end else if (cur != prev_q) begin
               prev_q      <= cur;
               match_cnt_q <= '0;
               if (state_q == ST_LOCKED) begin
                  state_q  <= ST_UNLOCKED;
                  locked_q <= 1'b0;
                  lost_q   <= 1'b1;
               end
            end else if (state_q == ST_UNLOCKED) begin
               if (match_cnt_q == CNT_W'(STABLE_ROUNDS - 1)) begin
                  state_q  <= ST_LOCKED;
                  fmt_q    <= cur;
                  locked_q <= 1'b1;
                  update_q <= 1'b1;
               end else begin
                  match_cnt_q <= match_cnt_q + 1'b1;
               end
            end
         end
      end
   end

   assign fmt_vid_std_o = fmt_q[VID_LSB +: 32];
   assign fmt_raster1_o = fmt_q[R1_LSB +: 16];
   assign fmt_raster2_o = fmt_q[R2_LSB +: 16];
   assign fmt_raster3_o = fmt_q[R3_LSB +: 16];
   assign fmt_raster4_o = fmt_q[R4_LSB +: 16];
   assign fmt_locked_o  = locked_q;
   assign fmt_update_o  = update_q;
   assign fmt_lost_o    = lost_q;

endmodule

// File: tb/tb_gs_fmt_monitor.sv
// Directed bench for gs_fmt_monitor with POLL_PERIOD=8, REGS_PER_ROUND=6, STABLE_ROUNDS=2.
// Cycle n means the interval just after the n-th rising edge following reset release / enable.
// Ticks land in cycle 8k-1, so results of tick k are visible in cycle 8k.
module tb_gs_fmt_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        stat_poll;
   logic [31:0] vid_std;
   logic [15:0] raster1, raster2, raster3, raster4;
   logic [31:0] fmt_vid_std;
   logic [15:0] fmt_raster1, fmt_raster2, fmt_raster3, fmt_raster4;
   logic        fmt_locked, fmt_update, fmt_lost;

   int n_assert = 0;
   int n_fail   = 0;

   // Pulse counters, written only by the monitor process.
   int upd_cnt  = 0;
   int lost_cnt = 0;
   int poll_cnt = 0;

   always #5 clk = ~clk;

   gs_fmt_monitor #(
      .POLL_PERIOD    (8),
      .REGS_PER_ROUND (6),
      .STABLE_ROUNDS  (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .enable_i      (enable),
      .stat_poll_o   (stat_poll),
      .vid_std_i     (vid_std),
      .raster1_i     (raster1),
      .raster2_i     (raster2),
      .raster3_i     (raster3),
      .raster4_i     (raster4),
      .fmt_vid_std_o (fmt_vid_std),
      .fmt_raster1_o (fmt_raster1),
      .fmt_raster2_o (fmt_raster2),
      .fmt_raster3_o (fmt_raster3),
      .fmt_raster4_o (fmt_raster4),
      .fmt_locked_o  (fmt_locked),
      .fmt_update_o  (fmt_update),
      .fmt_lost_o    (fmt_lost)
   );

   always @(negedge clk) begin
      if (fmt_update === 1'b1) upd_cnt  <= upd_cnt + 1;
      if (fmt_lost === 1'b1)   lost_cnt <= lost_cnt + 1;
      if (stat_poll === 1'b1)  poll_cnt <= poll_cnt + 1;
   end

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int base_upd, base_lost, base_poll;

   initial begin
      rst     = 1'b1;
      enable  = 1'b0;
      vid_std = 32'h0000_1234;
      raster1 = 16'd1125;
      raster2 = 16'd2200;
      raster3 = 16'd1080;
      raster4 = 16'd1920;

      // Reset state
      adv(1);
      chk("rst_poll",   96'(stat_poll),   96'd0);
      chk("rst_locked", 96'(fmt_locked),  96'd0);
      chk("rst_update", 96'(fmt_update),  96'd0);
      chk("rst_lost",   96'(fmt_lost),    96'd0);
      chk("rst_vid",    96'(fmt_vid_std), 96'd0);
      chk("rst_r1",     96'(fmt_raster1), 96'd0);

      // Poll cadence: cycle 0 starts now
      rst    = 1'b0;
      enable = 1'b1;
      adv(7);   // cycle 7
      chk("poll_c7",  96'(stat_poll), 96'd0);
      adv(1);   // cycle 8
      chk("poll_c8",  96'(stat_poll), 96'd1);
      adv(1);   // cycle 9
      chk("poll_c9",  96'(stat_poll), 96'd0);
      adv(7);   // cycle 16
      chk("poll_c16", 96'(stat_poll), 96'd1);

      // Lock: checks on ticks 7/13/19 -> lock visible in cycle 152
      adv(135); // cycle 151
      chk("pre_lock_locked", 96'(fmt_locked), 96'd0);
      adv(1);   // cycle 152
      chk("lock_locked", 96'(fmt_locked), 96'd1);
      chk("lock_update", 96'(fmt_update), 96'd1);
      chk("lock_vid",    96'(fmt_vid_std), 96'h1234);
      chk("lock_r1",     96'(fmt_raster1), 96'd1125);
      chk("lock_r2",     96'(fmt_raster2), 96'd2200);
      chk("lock_r3",     96'(fmt_raster3), 96'd1080);
      chk("lock_r4",     96'(fmt_raster4), 96'd1920);
      adv(1);   // cycle 153
      chk("lock_update_1cyc", 96'(fmt_update), 96'd0);
      chk("lock_update_cnt",  96'(upd_cnt),    96'd1);

      // Loss and relock: next check tick 25 (cycle 200), relock tick 37 (cycle 296)
      raster1 = 16'd625;
      adv(46);  // cycle 199
      chk("pre_loss_locked", 96'(fmt_locked), 96'd1);
      chk("pre_loss_lost",   96'(fmt_lost),   96'd0);
      adv(1);   // cycle 200
      chk("loss_lost",   96'(fmt_lost),   96'd1);
      chk("loss_locked", 96'(fmt_locked), 96'd0);
      chk("loss_update", 96'(fmt_update), 96'd0);
      adv(1);   // cycle 201
      chk("loss_lost_1cyc", 96'(fmt_lost), 96'd0);
      adv(47);  // cycle 248: first equal compare, no lock yet
      chk("relock_early", 96'(fmt_locked), 96'd0);
      adv(48);  // cycle 296
      chk("relock_locked", 96'(fmt_locked),  96'd1);
      chk("relock_update", 96'(fmt_update),  96'd1);
      chk("relock_r1",     96'(fmt_raster1), 96'd625);
      chk("relock_r2",     96'(fmt_raster2), 96'd2200);

      // Flicker: vid_std alternates between checks (ticks 43,49,55,61,67)
      adv(1);   // cycle 297
      base_upd = upd_cnt;
      vid_std  = 32'h1;
      adv(47);  // cycle 344
      chk("flicker_first_lost", 96'(fmt_lost), 96'd1);
      for (int i = 0; i < 4; i++) begin
         vid_std = (i % 2 == 0) ? 32'h2 : 32'h1;
         adv(48);
         chk("flicker_locked", 96'(fmt_locked), 96'd0);
      end
      chk("flicker_no_update", 96'(upd_cnt - base_upd), 96'd0);

      // Enable drop while locked: relock on ticks 73/79/85 (cycle 680)
      vid_std = 32'h0000_1234;
      adv(144); // cycle 680
      chk("en_lock_locked", 96'(fmt_locked), 96'd1);
      adv(10);  // cycle 690, mid-round
      base_lost = lost_cnt;
      base_poll = poll_cnt;
      base_upd  = upd_cnt;
      enable = 1'b0;
      adv(1);
      chk("en_drop_locked", 96'(fmt_locked), 96'd0);
      adv(10);
      chk("en_drop_polls", 96'(poll_cnt - base_poll), 96'd0);
      chk("en_drop_lost",  96'(lost_cnt - base_lost), 96'd0);
      chk("en_drop_upd",   96'(upd_cnt - base_upd),   96'd0);
      chk("en_drop_hold",  96'(fmt_vid_std), 96'h1234);

      // Re-enable: tick 7 only seeds prev, tick 13 counts, tick 19 locks
      enable = 1'b1;
      adv(8);
      chk("reen_first_poll", 96'(stat_poll), 96'd1);
      adv(48);  // cycle 56
      chk("reen_t7_locked", 96'(fmt_locked), 96'd0);
      chk("reen_t7_update", 96'(fmt_update), 96'd0);
      adv(48);  // cycle 104
      chk("reen_t13_locked", 96'(fmt_locked), 96'd0);
      adv(48);  // cycle 152
      chk("reen_t19_locked", 96'(fmt_locked), 96'd1);

      // Mid-operation reset while locked
      adv(20);
      rst = 1'b1;
      adv(1);
      chk("mrst_locked", 96'(fmt_locked),  96'd0);
      chk("mrst_poll",   96'(stat_poll),   96'd0);
      chk("mrst_vid",    96'(fmt_vid_std), 96'd0);
      chk("mrst_r1",     96'(fmt_raster1), 96'd0);
      rst = 1'b0;
      adv(7);
      chk("mrst_c7_poll", 96'(stat_poll), 96'd0);
      adv(1);
      chk("mrst_c8_poll", 96'(stat_poll), 96'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
